fifo_packer: RTL and testbench

//  Downstream stage of the single-clock fifo. Consumes P_WIDTH-bit words from
//  the fifo read port (vld/rdy) and packs P_RATIO words into one wide word for
//  the wide-bus consumer. A partial word is emitted early on flush or on idle

---
 rtl/fifo_packer.sv | 146 ++++++++++++++
 tb/tb_fifo_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer: packs P_RATIO narrow words from the fifo read port into one wide
// word, lane 0 first. A partial word is closed early by flush or idle timeout;
// such words carry a per-lane keep mask and a last marker.
module fifo_packer #(
  parameter int P_WIDTH   = 8,
  parameter int P_RATIO   = 4,
  parameter int P_TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P_WIDTH-1:0]           in_data,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic                         flush,
  output logic [P_WIDTH*P_RATIO-1:0]   out_data,
  output logic [P_RATIO-1:0]           out_keep,
  output logic                         out_last,
  output logic                         out_vld,
  input  logic                         out_rdy
);

  localparam int CW = $clog2(P_RATIO);
  localparam int IW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam int OW = P_WIDTH * P_RATIO;
  localparam bit TO_EN = (P_TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(P_RATIO - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {FILL, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [OW-1:0]   data_q, data_d;
  logic [P_RATIO-1:0] keep_q, keep_d;
  logic            last_q, last_d;
  logic            vld_q, vld_d;
  logic            accept;

  // The fill buffer doubles as the output register: in HOLD it is frozen,
  // so the held word is stable without a second copy.
  assign in_rdy   = rst_n & ((state_q == FILL) | out_rdy);
  assign accept   = in_vld & in_rdy;
  assign out_data = data_q;
  assign out_keep = keep_q;
  assign out_last = last_q;
  assign out_vld  = vld_q;

  // Next-state: lane fill, word closure (full / flush / timeout) and handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < P_RATIO; k++) begin
            if (cnt_q == CW'(k)) begin
              data_d[k*P_WIDTH +: P_WIDTH] = in_data;
              keep_d[k]                    = 1'b1;
            end
          end
          idle_d = '0;
          if (cnt_q == CNT_LAST) begin
            // Full word; a coincident flush only marks it last.
            state_d = HOLD;
            cnt_d   = '0;
            last_d  = flush;
          end else if (flush) begin
            state_d = HOLD;
            cnt_d   = '0;
            last_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q != '0) begin
          if (flush) begin
            state_d = HOLD;
            cnt_d   = '0;
            idle_d  = '0;
            last_d  = 1'b1;
          end else if (TO_EN) begin
            if (idle_q == IDLE_LAST) begin
              state_d = HOLD;
              cnt_d   = '0;
              idle_d  = '0;
              last_d  = 1'b1;
            end else begin
              idle_d = idle_q + IW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (out_rdy) begin
          // Handshake: a word offered on the same cycle lands in lane 0.
          state_d = FILL;
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          idle_d  = '0;
          if (accept) begin
            data_d[P_WIDTH-1:0] = in_data;
            keep_d[0]           = 1'b1;
            if (flush) begin
              state_d = HOLD;
              last_d  = 1'b1;
            end else begin
              cnt_d = CW'(1);
            end
          end
        end else if (flush) begin
          last_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    vld_d = (state_d == HOLD);
  end

  // State and datapath registers; reset discards any buffered or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: directed scenarios plus randomized traffic, checked by
// a queue-based reference model and a scoreboard monitor on the output port.
module tb_fifo_packer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int T  = 8;
  localparam int OW = W * R;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    in_data;
  logic            in_vld;
  logic            in_rdy;
  logic            flush;
  logic [OW-1:0]   out_data;
  logic [R-1:0]    out_keep;
  logic            out_last;
  logic            out_vld;
  logic            out_rdy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur[$];
  bit           m_held = 1'b0;
  int           m_idle = 0;

  fifo_packer #(.P_WIDTH(W), .P_RATIO(R), .P_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Close the words gathered so far into one expected output word.
  task automatic close_word(bit last);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    foreach (cur[k]) begin
      e.data[k*W +: W] = cur[k];
      e.keep[k]        = 1'b1;
    end
    e.last = last;
    exp_q.push_back(e);
    cur.delete();
    m_held = 1'b1;
    m_idle = 0;
  endtask

  // Reference model: a list of gathered words, a held flag and an idle count.
  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
      m_held = 1'b0;
      m_idle = 0;
    end else begin
      acc = in_vld && (!m_held || out_rdy);
      if (m_held) begin
        if (out_rdy) begin
          m_held = 1'b0;
          m_idle = 0;
          if (acc) begin
            cur.push_back(in_data);
            if (flush) close_word(1'b1);
          end
        end else if (flush && exp_q.size() > 0) begin
          exp_q[exp_q.size()-1].last = 1'b1;
        end
      end else begin
        if (acc) begin
          cur.push_back(in_data);
          m_idle = 0;
          if (cur.size() == R) close_word(flush);
          else if (flush) close_word(1'b1);
        end else if (cur.size() > 0) begin
          if (flush) close_word(1'b1);
          else begin
            m_idle++;
            if (m_idle == T) close_word(1'b1);
          end
        end
      end
    end
  end

  // Scoreboard monitor: samples on the falling edge, pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_vld", out_vld, m_held);
      chk("in_rdy", in_rdy, (!m_held || out_rdy));
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got out_vld=1 data %0h expected no word", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_keep", out_keep, exp_q[0].keep);
          chk("out_last", out_last, exp_q[0].last);
          if (out_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(bit v, logic [W-1:0] d, bit f, bit r);
    in_vld  = v;
    in_data = d;
    flush   = f;
    out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pv;
    in_vld = 1'b0; in_data = '0; flush = 1'b0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_keep", out_keep, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_rdy", in_rdy, 1'b1);

    // Back-to-back full words with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'((i + 1) * 8'h11), 1'b0, 1'b1);
      if (i == 3) begin
        chk("t1_vld", out_vld, 1'b1);
        chk("t1_data", out_data, 32'h44332211);
        chk("t1_keep", out_keep, 4'b1111);
        chk("t1_last", out_last, 1'b0);
      end
    end
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);

    // Back-pressure in HOLD, then handshake with a word landing in lane 0.
    for (int i = 0; i < 4; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    chk("t2_in_rdy", in_rdy, 1'b0);
    chk("t2_stable", out_data, 32'h04030201);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("t2_vld_drop", out_vld, 1'b0);
    chk("t2_lane0", out_data, 32'h00000055);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b1, 8'h88, 1'b0, 1'b1);
    chk("t2_word", out_data, 32'h88776655);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1);

    // Flush of a partial word.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t3_data", out_data, 32'h0000BBAA);
    chk("t3_keep", out_keep, 4'b0011);
    chk("t3_last", out_last, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Idle timeout on a single buffered word; empty idle never emits.
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    for (int k = 1; k <= T; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t4_timeout_vld", out_vld, (k == T));
    end
    chk("t4_data", out_data, 32'h0000005A);
    chk("t4_keep", out_keep, 4'b0001);
    repeat (20) step(1'b0, '0, 1'b0, 1'b1);

    // Flush with nothing buffered; flush while held and not taken.
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t5_empty_flush", out_vld, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    chk("t5_last_before", out_last, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t5_last_after", out_last, 1'b1);
    chk("t5_data", out_data, 32'h13121110);
    chk("t5_keep", out_keep, 4'b1111);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset while holding a word.
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_vld", out_vld, 1'b0);
    chk("t6_data", out_data, '0);
    chk("t6_keep", out_keep, '0);
    chk("t6_in_rdy", in_rdy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'hA1 + i), 1'b0, 1'b1);
    chk("t6_repack", out_data, 32'hA4A3A2A1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with varying input density.
    for (int ph = 0; ph < 6; ph++) begin
      pv = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 50 : 10);
      repeat (500) begin
        step(($urandom_range(0, 99) < pv), W'($urandom),
             ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70));
      end
    end

    // Drain anything still buffered or held.
    repeat (30) step(1'b0, '0, 1'b0, 1'b1);
    chk("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
